// File: rtl/wrap_event_timer_pkg.sv
// Shared types and constants for the wrap-around event timer.
package wrap_event_timer_pkg;

  localparam int unsigned W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wrap_event_timer.sv
// Counts upstream terminal-count ticks and raises a level irq every `period`
// ticks, in periodic or one-shot mode, with a sticky overrun flag.
module wrap_event_timer
  import wrap_event_timer_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic [W-1:0] period,
  input  logic         irq_ack,
  output logic         busy,
  output logic         irq,
  output logic         overrun,
  output logic [W-1:0] event_cnt
);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_q, per_d;
  logic         os_q, os_d;
  logic         irq_q, irq_d;
  logic         ovr_q, ovr_d;

  logic         start_ok;
  logic         expire;

  assign start_ok = start && !stop && (period != W'(0));
  assign expire   = (state_q == RUN) && tick && (cnt_q == W'(per_q - W'(1)));

  // State and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      os_q    <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      os_q    <= os_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and datapath update; stop beats start, start beats tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    os_d    = os_q;
    irq_d   = irq_q && !irq_ack;
    ovr_d   = ovr_q;

    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (start_ok) begin
      state_d = RUN;
      cnt_d   = '0;
      per_d   = period;
      os_d    = oneshot;
      ovr_d   = 1'b0;
    end else if (state_q == RUN && tick) begin
      if (expire) begin
        cnt_d = '0;
        irq_d = 1'b1;
        if (irq_q && !irq_ack) begin
          ovr_d = 1'b1;
        end
        if (os_q) begin
          state_d = IDLE;
        end
      end else begin
        cnt_d = W'(cnt_q + W'(1));
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign irq       = irq_q;
  assign overrun   = ovr_q;
  assign event_cnt = cnt_q;

endmodule

// File: tb/tb_wrap_event_timer.sv
// Directed self-checking bench for wrap_event_timer.
module tb_wrap_event_timer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic         tick, start, stop, oneshot, irq_ack;
  logic [W-1:0] period;
  logic         busy, irq, overrun;
  logic [W-1:0] event_cnt;

  int checks = 0;
  int errors = 0;

  wrap_event_timer #(.W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .period    (period),
    .irq_ack   (irq_ack),
    .busy      (busy),
    .irq       (irq),
    .overrun   (overrun),
    .event_cnt (event_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    tick = 0; start = 0; stop = 0; irq_ack = 0;
  endtask

  task automatic do_start(input logic [W-1:0] p, input logic os);
    start = 1; period = p; oneshot = os;
    cyc();
    start = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1;
    for (int i = 0; i < n; i++) cyc();
    tick = 0;
  endtask

  task automatic ack();
    irq_ack = 1;
    cyc();
    irq_ack = 0;
  endtask

  initial begin
    rstn = 0; period = '0; oneshot = 0;
    idle_in();
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_cnt", 32'(event_cnt), 0);
    rstn = 1;
    #2;

    // Periodic, period 3, 7 ticks without ack
    do_start(8'd3, 1'b0);
    check("p3_busy", 32'(busy), 1);
    check("p3_cnt0", 32'(event_cnt), 0);
    ticks(2);
    check("p3_cnt2", 32'(event_cnt), 2);
    check("p3_noirq", 32'(irq), 0);
    ticks(1);
    check("p3_irq3", 32'(irq), 1);
    check("p3_wrap", 32'(event_cnt), 0);
    check("p3_ovr3", 32'(overrun), 0);
    ticks(3);
    check("p3_ovr6", 32'(overrun), 1);
    check("p3_busy6", 32'(busy), 1);
    ticks(1);
    check("p3_cnt7", 32'(event_cnt), 1);

    // Clear irq, stop; overrun stays sticky through stop
    ack();
    check("ack_irq", 32'(irq), 0);
    stop = 1; cyc(); stop = 0;
    check("stop_busy", 32'(busy), 0);
    check("stop_ovr", 32'(overrun), 1);

    // One-shot, period 2
    do_start(8'd2, 1'b1);
    check("os_ovr_clr", 32'(overrun), 0);
    ticks(2);
    check("os_irq", 32'(irq), 1);
    check("os_busy", 32'(busy), 0);
    ticks(1);
    check("os_idle_tick", 32'(event_cnt), 0);
    ack();

    // Periodic, period 1, tick and ack every cycle
    do_start(8'd1, 1'b0);
    tick = 1; irq_ack = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("p1_irq", 32'(irq), 1);
      check("p1_ovr", 32'(overrun), 0);
      check("p1_cnt", 32'(event_cnt), 0);
    end
    tick = 0;
    cyc();
    check("p1_ack_clr", 32'(irq), 0);
    irq_ack = 0;

    // stop with same-cycle tick, then start+stop
    do_start(8'd5, 1'b0);
    ticks(2);
    check("st_cnt2", 32'(event_cnt), 2);
    stop = 1; tick = 1; cyc(); stop = 0; tick = 0;
    check("st_busy", 32'(busy), 0);
    check("st_cnt", 32'(event_cnt), 0);
    start = 1; stop = 1; period = 8'd5; cyc(); start = 0; stop = 0;
    check("ss_busy", 32'(busy), 0);

    // Zero period ignored; async reset mid-count
    do_start(8'd0, 1'b0);
    check("p0_busy", 32'(busy), 0);
    do_start(8'd8, 1'b0);
    ticks(5);
    check("mr_cnt5", 32'(event_cnt), 5);
    #2 rstn = 0;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_cnt", 32'(event_cnt), 0);
    check("mr_irq", 32'(irq), 0);
    check("mr_ovr", 32'(overrun), 0);
    #2 rstn = 1;
    ticks(3);
    check("mr_noirq", 32'(irq), 0);
    check("mr_idle_cnt", 32'(event_cnt), 0);
    do_start(8'd2, 1'b0);
    check("mr_restart", 32'(busy), 1);

    // Restart while irq and overrun pending
    ticks(4);
    check("rs_irq", 32'(irq), 1);
    check("rs_ovr", 32'(overrun), 1);
    ticks(1);
    start = 1; tick = 1; period = 8'd4; oneshot = 0; cyc(); start = 0; tick = 0;
    check("rs_cnt", 32'(event_cnt), 0);
    check("rs_ovr_clr", 32'(overrun), 0);
    check("rs_irq_kept", 32'(irq), 1);
    cyc();
    check("rs_irq_hold", 32'(irq), 1);
    ack();
    check("rs_irq_ack", 32'(irq), 0);
    ticks(3);
    check("rs_p4_cnt3", 32'(event_cnt), 3);
    check("rs_p4_noirq", 32'(irq), 0);
    ticks(1);
    check("rs_p4_irq", 32'(irq), 1);
    check("rs_p4_wrap", 32'(event_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrap_event_timer.md
WRAP_EVENT_TIMER -- requirements
Module: wrap_event_timer

Interface
REQ-001 Parameter W, default 8: width of period and event counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 tick  input  1  single-cycle terminal-count pulse from the upstream binary counter's done output.
REQ-005 start  input  1  arm/restart request, sampled each clk.
REQ-006 stop  input  1  disarm request, sampled each clk.
REQ-007 oneshot  input  1  mode select, latched on accepted start (1 = one-shot, 0 = periodic).
REQ-008 period  input  W  ticks per event, latched on accepted start.
REQ-009 irq_ack  input  1  clears irq.
REQ-010 busy  output  1  high while in RUN.
REQ-011 irq  output  1  level event flag, held until acknowledged.
REQ-012 overrun  output  1  sticky: event occurred while irq already pending.
REQ-013 event_cnt  output  W  ticks counted in current period.

Function
REQ-014 FSM shall have two states, IDLE and RUN; busy = (state == RUN), registered.
REQ-015 In IDLE, start=1 with period != 0 and stop=0 shall latch period/oneshot, clear event_cnt and overrun, and enter RUN next cycle.
REQ-016 start with period == 0 shall be ignored (remain IDLE, or remain RUN unchanged).
REQ-017 In RUN, each tick=1 shall increment event_cnt by 1, visible the cycle after tick is sampled.
REQ-018 Expiry = tick sampled while event_cnt == latched_period-1; event_cnt shall then wrap to 0 and irq shall be 1 next cycle.
REQ-019 On expiry in periodic mode, the FSM shall stay in RUN; in one-shot mode it shall return to IDLE.
REQ-020 On expiry with irq already 1 and irq_ack=0, overrun shall set to 1 and remain set until reset or accepted start.
REQ-021 irq_ack=1 shall clear irq next cycle, except on a same-cycle expiry, where irq shall stay 1 and overrun shall not set.
REQ-022 stop=1 shall force IDLE next cycle, clear event_cnt, and discard any same-cycle tick; irq and overrun shall be retained.
REQ-023 Simultaneous start and stop: stop wins.
REQ-024 start in RUN (period != 0, stop=0) shall restart: reload period/oneshot, clear event_cnt and overrun; a same-cycle tick shall be discarded; irq shall be retained.
REQ-025 tick in IDLE shall be ignored.
REQ-026 Arithmetic shall be W bits unsigned; event_cnt shall never exceed latched_period-1.

Reset
REQ-027 rstn=0 shall, asynchronously, force state=IDLE, busy=0, irq=0, overrun=0, event_cnt=0, latched period=0, latched oneshot=0.
REQ-028 Reset asserted mid-count shall abandon the count; no irq shall be generated for the interrupted period.
REQ-029 Reset deassertion shall require no additional cycles before start is accepted.

Structure
REQ-030 Shared package wrap_event_timer_pkg shall hold the state enum (IDLE, RUN) and the default W constant.
REQ-031 The block shall be a single module with no sub-modules; the upstream tick source shall be instantiated by the integrator, not inside this block.

Verification
REQ-032 Periodic, period=3: start, then 7 ticks -> irq rises after tick 3 and after tick 6 with no ack after tick 3 -> overrun=1 after tick 6, event_cnt=1 after tick 7.
REQ-033 One-shot, period=2: start, 2 ticks -> irq=1, busy=0 the cycle after tick 2; a 3rd tick leaves event_cnt=0.
REQ-034 Periodic, period=1: tick every cycle with irq_ack every cycle -> irq stays 1, overrun stays 0.
REQ-035 Running, event_cnt=2: stop+tick same cycle -> IDLE, event_cnt=0; start+stop same cycle -> stays IDLE.
REQ-036 start with period=0 -> busy stays 0; rstn pulsed low mid-count at event_cnt=5 -> all outputs 0 immediately, no irq.
REQ-037 Running with irq=1, overrun=1: start with period=4 -> event_cnt=0, overrun=0, irq remains 1 until irq_ack.
